quad_step_decoder: RTL and testbench

- Front end for the 16-bit up/down counter: turns asynchronous quadrature encoder channels A/B into the single-cycle increase/decrease strobes that the counter consumes.
- Stages, in order: per-channel synchroniser, per-channel glitch filter, start-up settling FSM, Gray-step decoder.
- Output strobes connect directly to the counter's increase/decrease inputs on the same clock.

---
 rtl/quad_pkg.sv | 38 +++
 rtl/quad_glitch_filter.sv | 49 ++++
 rtl/quad_step_decoder.sv | 116 +++++++++++
 tb/tb_quad_step_decoder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature step decoder.
//   state_t       : start-up settling FSM states
//   step_t        : classification of one filtered {A,B} update
//   classify_step : maps (previous, current) {A,B} to a step_t
package quad_pkg;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_FILTER_CYCLES = 4;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILLEGAL
  } step_t;

  // Forward Gray order is 00 -> 01 -> 11 -> 10 -> 00; any other single-bit change is reverse.
  function automatic step_t classify_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t step;
    case (prev ^ cur)
      2'b00:   step = STEP_NONE;
      2'b11:   step = STEP_ILLEGAL;
      default: begin
        case ({prev, cur})
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step = STEP_FWD;
          default:                                step = STEP_REV;
        endcase
      end
    endcase
    return step;
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Synchroniser plus persistence filter for one encoder channel.
//   clock, reset : system clock, async active-high reset
//   bypass       : when high the filtered level follows the synchronised level every cycle
//   din          : asynchronous channel input
//   level        : filtered, registered channel level
module quad_glitch_filter #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic bypass,
  input  logic din,
  output logic level
);

  localparam int unsigned CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchroniser chain and persistence counter; a new level is accepted only after
  // it has differed from the filtered level for FILTER_CYCLES consecutive cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (bypass) begin
        level <= synced;
        cnt   <= '0;
      end else if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= synced;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronise and filter A/B, settle after reset,
// then decode Gray steps into single-cycle increase/decrease strobes.
//   clock, reset : system clock, async active-high reset
//   enable       : gates increase/decrease only; tracking and error counting continue
//   chan_a/b     : asynchronous encoder channels
//   increase     : one-cycle strobe per forward step
//   decrease     : one-cycle strobe per reverse step
//   illegal      : one-cycle strobe when both channels change in one filtered update
//   state_ab     : current filtered {A,B}
//   error_count  : saturating count of illegal events
//   ready        : high once settling has finished
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             chan_a,
  input  logic             chan_b,
  output logic             increase,
  output logic             decrease,
  output logic             illegal,
  output logic [1:0]       state_ab,
  output logic [ERR_W-1:0] error_count,
  output logic             ready
);

  localparam int unsigned SETTLE = SYNC_STAGES + FILTER_CYCLES;
  localparam int unsigned SET_W  = $clog2(SETTLE);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

  state_t           state, state_nxt;
  logic [SET_W-1:0] settle_cnt, settle_nxt;
  logic [1:0]       prev_ab;
  logic             filt_a, filt_b;
  logic             bypass;
  logic             run;
  step_t            step;

  assign bypass   = (state == ST_INIT);
  assign run      = (state == ST_RUN);
  assign state_ab = {filt_a, filt_b};
  assign step     = classify_step(prev_ab, state_ab);

  quad_glitch_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filt_a (
    .clock (clock),
    .reset (reset),
    .bypass(bypass),
    .din   (chan_a),
    .level (filt_a)
  );

  quad_glitch_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filt_b (
    .clock (clock),
    .reset (reset),
    .bypass(bypass),
    .din   (chan_b),
    .level (filt_b)
  );

  // Settling FSM next state: INIT lasts SETTLE cycles so the synchronisers and
  // filters absorb the current encoder position without producing steps.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      ST_INIT: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          settle_nxt = settle_cnt + SET_W'(1);
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // State register and registered decoder outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_INIT;
      settle_cnt  <= '0;
      prev_ab     <= '0;
      increase    <= 1'b0;
      decrease    <= 1'b0;
      illegal     <= 1'b0;
      error_count <= '0;
      ready       <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      ready      <= (state_nxt == ST_RUN);
      // Tracking continues with enable low so re-enabling causes no catch-up burst.
      prev_ab    <= state_ab;
      increase   <= run && enable && (step == STEP_FWD);
      decrease   <= run && enable && (step == STEP_REV);
      illegal    <= run && (step == STEP_ILLEGAL);
      if (run && (step == STEP_ILLEGAL) && (error_count != {ERR_W{1'b1}})) begin
        error_count <= error_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Self-checking bench for quad_step_decoder: directed scenarios plus random
// stimulus, all checked cycle by cycle against a behavioural model.
module tb_quad_step_decoder;

  localparam int S      = 2;
  localparam int F      = 4;
  localparam int SETTLE = S + F;
  localparam int LAT    = S + F + 1;
  localparam int EMAX   = 255;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       chan_a = 1'b0;
  logic       chan_b = 1'b0;
  logic       increase, decrease, illegal, ready;
  logic [1:0] state_ab;
  logic [7:0] error_count;

  quad_step_decoder #(
    .SYNC_STAGES  (S),
    .FILTER_CYCLES(F),
    .ERR_W        (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .chan_a     (chan_a),
    .chan_b     (chan_b),
    .increase   (increase),
    .decrease   (decrease),
    .illegal    (illegal),
    .state_ab   (state_ab),
    .error_count(error_count),
    .ready      (ready)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Edges are numbered from 1 after reset release; xh holds the {A,B} sampled at each edge.
  int         k;
  logic [1:0] xh[$];
  logic [1:0] m_filt, m_prev;
  int         m_restart[2];
  int         m_err;
  bit         e_inc, e_dec, e_ill, e_rdy;

  function automatic int gray_pos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Level seen at the synchroniser output just before edge j.
  function automatic logic [1:0] seen_at(input int j);
    int idx;
    idx = j - S;
    if (idx < 1) return 2'b00;
    return xh[idx-1];
  endfunction

  task automatic model_clear();
    k = 0;
    xh.delete();
    m_filt = 2'b00;
    m_prev = 2'b00;
    m_restart[0] = 0;
    m_restart[1] = 0;
    m_err = 0;
    e_inc = 0; e_dec = 0; e_ill = 0; e_rdy = 0;
  endtask

  task automatic model_edge();
    logic [1:0] s, fo, w;
    bit         run_old, ok;
    int         d;
    k++;
    xh.push_back({chan_a, chan_b});
    s       = seen_at(k);
    run_old = (k > SETTLE);
    fo      = m_filt;
    e_inc = 0; e_dec = 0; e_ill = 0;
    if (run_old) begin
      d     = (gray_pos(fo) - gray_pos(m_prev) + 4) % 4;
      e_inc = (d == 1) && enable;
      e_dec = (d == 3) && enable;
      e_ill = (d == 2);
      if (e_ill && m_err < EMAX) m_err++;
    end
    m_prev = fo;
    for (int i = 0; i < 2; i++) begin
      if (!run_old) begin
        m_filt[i]    = s[i];
        m_restart[i] = k;
      end else if (k - m_restart[i] >= F) begin
        // accept once the last F seen levels all differ from the filtered level
        ok = 1;
        for (int j = 0; j < F; j++) begin
          w = seen_at(k - j);
          if (w[i] == fo[i]) ok = 0;
        end
        if (ok) begin
          m_filt[i]    = s[i];
          m_restart[i] = k;
        end
      end
    end
    e_rdy = (k >= SETTLE);
  endtask

  // ---------------- stimulus helpers ----------------
  int cyc = 0;
  int c_inc, c_dec, c_ill;
  int chg_edge;
  bit lat_on = 0;

  task automatic clear_counts();
    c_inc = 0; c_dec = 0; c_ill = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    model_edge();
    #1;
    check("increase", increase, e_inc);
    check("decrease", decrease, e_dec);
    check("illegal", illegal, e_ill);
    check("state_ab", state_ab, m_filt);
    check("error_count", error_count, m_err);
    check("ready", ready, e_rdy);
    if (increase) c_inc++;
    if (decrease) c_dec++;
    if (illegal)  c_ill++;
    // latency counts the sampling edge as cycle 1
    if (lat_on && (increase || decrease))
      check("latency", cyc - chg_edge + 1, LAT);
  endtask

  task automatic drive(input logic [1:0] v, input int n);
    if ({chan_a, chan_b} != v) chg_edge = cyc + 1;
    chan_a = v[1];
    chan_b = v[0];
    repeat (n) tick();
  endtask

  task automatic do_reset();
    int first;
    reset = 1'b1;
    #1;
    check("rst_increase", increase, 0);
    check("rst_decrease", decrease, 0);
    check("rst_illegal", illegal, 0);
    check("rst_state_ab", state_ab, 0);
    check("rst_error_count", error_count, 0);
    check("rst_ready", ready, 0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
    clear_counts();
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ready && first == 0) first = i;
    end
    check("ready_cycle", first, SETTLE);
    check("settle_strobes", c_inc + c_dec + c_ill, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] fwd_from_11[4] = '{2'b10, 2'b00, 2'b01, 2'b11};
  logic [1:0] rev_from_11[4] = '{2'b01, 2'b00, 2'b10, 2'b11};
  logic [1:0] fwd_from_00[4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  initial begin
    model_clear();
    #3;

    // Settle on 11 held through reset.
    chan_a = 1'b1; chan_b = 1'b1;
    do_reset();
    check("init_state_ab", state_ab, 2'b11);

    // Four forward steps.
    clear_counts();
    lat_on = 1;
    for (int i = 0; i < 4; i++) drive(fwd_from_11[i], 10);
    check("fwd_inc", c_inc, 4);
    check("fwd_dec", c_dec, 0);
    check("fwd_ill", c_ill, 0);

    // Four reverse steps.
    clear_counts();
    for (int i = 0; i < 4; i++) drive(rev_from_11[i], 10);
    check("rev_dec", c_dec, 4);
    check("rev_inc", c_inc, 0);
    lat_on = 0;

    // Glitches on stable 00: a short pulse is rejected, a long one is two steps.
    drive(2'b01, 10);
    drive(2'b00, 10);
    clear_counts();
    drive(2'b10, 3);
    drive(2'b00, 12);
    check("glitch3_strobes", c_inc + c_dec + c_ill, 0);
    check("glitch3_state", state_ab, 2'b00);
    clear_counts();
    drive(2'b10, 5);
    drive(2'b00, 12);
    check("pulse5_dec", c_dec, 1);
    check("pulse5_inc", c_inc, 1);

    // Illegal double change, then saturation.
    clear_counts();
    drive(2'b11, 8);
    check("ill_once", c_ill, 1);
    check("ill_err1", error_count, 1);
    check("ill_nostep", c_inc + c_dec, 0);
    for (int i = 1; i < 300; i++) drive((i % 2) ? 2'b00 : 2'b11, 6);
    check("ill_sat", error_count, EMAX);
    drive(2'b11, 8);
    check("ill_sat_hold", error_count, EMAX);

    // Back to 00 legally, then enable gating.
    drive(2'b10, 8);
    drive(2'b00, 8);
    clear_counts();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) drive(fwd_from_00[i], 8);
    check("dis_strobes", c_inc + c_dec, 0);
    enable = 1'b1;
    drive(2'b00, 4);
    clear_counts();
    drive(2'b01, 10);
    check("reen_inc", c_inc, 1);
    check("reen_dec", c_dec, 0);

    // Reset in the middle of a forward sequence.
    drive(2'b11, 8);
    drive(2'b10, 3);
    do_reset();
    drive(2'b10, 6);

    // Random stimulus.
    for (int n = 0; n < 400; n++) begin
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      drive(2'($urandom_range(0, 3)), $urandom_range(1, 12));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
